// File: rtl/core_run_sequencer_pkg.sv
// Shared definitions for the core run sequencer: FSM state encoding and default timeout.
package core_run_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_START,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } seq_state_t;

    localparam logic [15:0] DEFAULT_TIMEOUT = 16'd4000;

endpackage

// File: rtl/core_run_sequencer_sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/core_run_sequencer.sv
// Preloads the core's data memory from a host byte stream, pulses req, then times the run
// until ack or timeout and reports done/timed_out with the latched cycle count.
module core_run_sequencer
    import core_run_sequencer_pkg::*;
#(
    parameter int unsigned           CYCLE_BITS     = 16,
    parameter logic [CYCLE_BITS-1:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned           ADDR_BITS      = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  go,
    input  logic                  skip_preload,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    input  logic [ADDR_BITS-1:0]  pl_addr,
    input  logic [7:0]            pl_data,
    input  logic                  pl_last,
    output logic                  dm_we,
    output logic [ADDR_BITS-1:0]  dm_addr,
    output logic [7:0]            dm_wdata,
    output logic                  req,
    input  logic                  ack,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic [CYCLE_BITS-1:0] cycle_count
);

    seq_state_t            state, next_state;
    logic [CYCLE_BITS-1:0] count;
    logic                  go_accept;
    logic                  beat_accept;
    logic                  cnt_enable;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        go_accept  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (go) begin
                    go_accept  = 1'b1;
                    next_state = skip_preload ? S_START : S_PRELOAD;
                end
            end
            S_PRELOAD: begin
                if (pl_valid && pl_last) begin
                    next_state = S_START;
                end
            end
            S_START: next_state = S_RUN;
            S_RUN: begin
                // ack has priority over a timeout landing on the same cycle
                if (ack) begin
                    next_state = S_DONE;
                end else if (count == TIMEOUT_CYCLES) begin
                    next_state = S_TIMEOUT;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Counting during START makes the counter read 1 in the first RUN cycle.
    always_comb begin
        pl_ready    = (state == S_PRELOAD);
        beat_accept = pl_ready && pl_valid;
        cnt_enable  = (state == S_START) || ((state == S_RUN) && (next_state == S_RUN));
    end

    sat_counter #(
        .WIDTH (CYCLE_BITS)
    ) u_cycle_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (go_accept),
        .enable  (cnt_enable),
        .count   (count)
    );

    // Status outputs are registered from next_state so they align with the state they decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            req         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
        end else begin
            dm_we <= beat_accept;
            if (beat_accept) begin
                dm_addr  <= pl_addr;
                dm_wdata <= pl_data;
            end
            req       <= (next_state == S_START);
            busy      <= (next_state == S_PRELOAD) || (next_state == S_START) || (next_state == S_RUN);
            done      <= (next_state == S_DONE);
            timed_out <= (next_state == S_TIMEOUT);
            if ((state == S_RUN) && (next_state != S_RUN)) begin
                cycle_count <= count;
            end
        end
    end

endmodule

// File: doc/core_run_sequencer.md
Name: core_run_sequencer

Overview:
Upstream controller for the single-cycle 8-bit core. It preloads the core's data memory from a host byte stream, then pulses the core's req/start line and waits for ack. While waiting it counts execution cycles and enforces a timeout. It reports done/timeout status and the latched cycle count to the testbench or host wrapper.

Parameters:
CYCLE_BITS, 16, width of the execution cycle counter and of cycle_count.
TIMEOUT_CYCLES, 16'd4000, number of RUN cycles without ack before the run is aborted. Must be at least 1.
ADDR_BITS, 8, data-memory address width; matches the core's 8-bit ALU-driven address.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
go  in  1  start-a-run request; level, sampled only in IDLE/DONE/TIMEOUT
skip_preload  in  1  sampled with go; 1 = bypass PRELOAD
pl_valid  in  1  preload beat valid
pl_ready  out  1  preload beat accepted when pl_valid & pl_ready
pl_addr  in  ADDR_BITS  data-memory address of the beat
pl_data  in  8  byte to write
pl_last  in  1  final beat of the preload
dm_we  out  1  data-memory write enable (shared write port, muxed in front of the core)
dm_addr  out  ADDR_BITS  data-memory write address
dm_wdata  out  8  data-memory write data
req  out  1  core start pulse (drives the core's req)
ack  in  1  core done (pc == done address)
busy  out  1  high in PRELOAD, START, RUN
done  out  1  run finished with ack
timed_out  out  1  run aborted by timeout
cycle_count  out  CYCLE_BITS  RUN cycles to ack (or TIMEOUT_CYCLES on timeout)

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs are 0: pl_ready, dm_we, dm_addr, dm_wdata, req, busy, done, timed_out, cycle_count. Counter is cleared. Reset asserted mid-run aborts immediately; no partial status is kept.
- States: IDLE, PRELOAD, START, RUN, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT on go=1:
  - Clear done, timed_out and the counter; cycle_count keeps its value until the next latch.
  - Go to PRELOAD, or to START if skip_preload=1.
  - go has no effect in any other state.
- PRELOAD:
  - pl_ready=1 combinationally in this state only.
  - An accepted beat registers dm_we=1, dm_addr=pl_addr and dm_wdata=pl_data on the next edge. The write therefore occurs exactly one cycle after acceptance.
  - dm_we is 0 in every cycle that follows no accepted beat.
  - An accepted beat with pl_last=1 moves the FSM to START. Its write still issues in the first START cycle.
  - No beat limit applies; an address may be written repeatedly, and the last write wins.
- START: lasts exactly 1 cycle, with req=1 registered (high for exactly one clock). ack is ignored here because pc is still stale. Next state is RUN.
- RUN:
  - req=0. The counter increments once per cycle, starting at 1 in the first RUN cycle.
  - ack=1 → DONE, with cycle_count latched to the counter value of that cycle (ack in the first RUN cycle gives 1).
  - If the counter reaches TIMEOUT_CYCLES with ack=0 → TIMEOUT, with cycle_count=TIMEOUT_CYCLES.
  - If ack and the timeout coincide in the same cycle, ack wins (DONE).
  - The counter saturates and never wraps; TIMEOUT_CYCLES < 2^CYCLE_BITS is required.
- DONE: done=1 held until the next accepted go or reset.
- TIMEOUT: timed_out=1 held the same way.
- done and timed_out are never high simultaneously.
- busy is the registered decode of state ∈ {PRELOAD, START, RUN}.
- When dm_we=0 the core owns the memory port. The sequencer never asserts dm_we in START/RUN, except for the single trailing write from the last beat in the first START cycle.

Decomposition:
- Shared package (definitions): seq_state_t enum for the six states; constant DEFAULT_TIMEOUT.
- One natural sub-module: sat_counter (parameterized width, with clear, enable and saturate), used for the RUN cycle counter.
- FSM, preload register stage and status flags stay in core_run_sequencer.

Test Plan:
1. Reset check: hold reset_n=0 mid-RUN (counter=37) → all outputs 0 immediately, state IDLE. After release, no req occurs without go.
2. Normal run: go=1, skip_preload=0, send 3 beats {(0x10,0xAA),(0x11,0xBB),(0x12,0xCC,last)}.
   - Expect: dm_we pulses with matching addr/data one cycle after each accept.
   - Expect: req high for exactly 1 cycle.
   - Drive ack=1 at the 5th RUN cycle → done=1, cycle_count=5, busy=0.
3. Preload backpressure: pl_valid toggled 1,0,1(last) with gaps → only accepted beats write. dm_we=0 in gap cycles, and the FSM reaches START only after the last beat.
4. Timeout: TIMEOUT_CYCLES=8, skip_preload=1, ack held 0 → timed_out=1 after 8 RUN cycles, cycle_count=8, done=0. A second go clears timed_out.
5. Boundary races:
   - ack asserted during START → ignored.
   - ack in the first RUN cycle → cycle_count=1.
   - ack on the cycle the counter hits TIMEOUT_CYCLES → done=1, timed_out=0.
6. go while busy (PRELOAD/RUN) → no restart and no status change. go held high in DONE → immediate new run with done cleared.
